// File: rtl/ud_sweep_if.sv
// ud_sweep_if: request/grant bundle between two sweep requesters and ud_sweep_ctrl.
interface ud_sweep_if #(parameter int WIDTH = 4);
    logic             req0, req1, dir0, dir1;
    logic [WIDTH-1:0] start0, start1, stop0, stop1;
    logic [1:0]       gnt;
    logic             busy, done, m;
    logic [WIDTH-1:0] count;
    modport master (
        output req0, req1, dir0, dir1, start0, start1, stop0, stop1,
        input  gnt, busy, done, m, count
    );
    modport slave (
        input  req0, req1, dir0, dir1, start0, start1, stop0, stop1,
        output gnt, busy, done, m, count
    );
endinterface

// File: rtl/ud_sweep_ctrl.sv
// ud_sweep_ctrl: arbitrates two requesters onto one up/down sweep counter.
// Define UD_SWEEP_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ud_sweep_ctrl #(parameter int WIDTH = 4) (
    input logic     clk,
    input logic     reset,
    ud_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [1:0]       gnt_q, gnt_nx;
    logic             m_q, m_nx;
    logic [WIDTH-1:0] count_q, count_nx, stop_q, stop_nx, step;
    logic             any_req, win, own_req;
`ifdef UD_SWEEP_RR_EN
    logic ptr_q, ptr_nx;
    // ptr names the requester favoured when both ask at once
    assign win = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
`else
    assign win = !bus.req0;
`endif
    assign any_req = bus.req0 || bus.req1;
    assign own_req = gnt_q[0] ? bus.req0 : bus.req1;
    assign step    = m_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_q;
        m_nx     = m_q;
        count_nx = count_q;
        stop_nx  = stop_q;
`ifdef UD_SWEEP_RR_EN
        ptr_nx   = ptr_q;
`endif
        case (state)
            IDLE: if (any_req) begin
                gnt_nx   = win ? 2'b10 : 2'b01;
                m_nx     = win ? bus.dir1 : bus.dir0;
                count_nx = win ? bus.start1 : bus.start0;
                stop_nx  = win ? bus.stop1 : bus.stop0;
                state_nx = (count_nx == stop_nx) ? DONE : RUN;
`ifdef UD_SWEEP_RR_EN
                ptr_nx   = !win;
`endif
            end
            RUN: if (!own_req) begin
                state_nx = IDLE;
                gnt_nx   = 2'b00;
            end else begin
                count_nx = step;
                state_nx = (step == stop_q) ? DONE : RUN;
            end
            DONE: begin
                state_nx = IDLE;
                gnt_nx   = 2'b00;
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 2'b00;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt_q   <= 2'b00;
            m_q     <= 1'b0;
            count_q <= '0;
            stop_q  <= '0;
`ifdef UD_SWEEP_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            gnt_q   <= gnt_nx;
            m_q     <= m_nx;
            count_q <= count_nx;
            stop_q  <= stop_nx;
`ifdef UD_SWEEP_RR_EN
            ptr_q   <= ptr_nx;
`endif
        end
    end
    assign bus.gnt   = gnt_q;
    assign bus.busy  = state != IDLE;
    assign bus.done  = state == DONE;
    assign bus.m     = m_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_ud_sweep_ctrl.sv
// tb_ud_sweep_ctrl: directed vectors for ud_sweep_ctrl (WIDTH = 4).
module tb_ud_sweep_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [1:0] exp_g [3];
    ud_sweep_if #(.WIDTH(4)) bus ();
    ud_sweep_ctrl #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic outs(input string tag, input logic [1:0] g, input logic b, input logic d, input logic mm, input logic [3:0] c);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
        chk({tag, ".m"}, 32'(bus.m), 32'(mm));
        chk({tag, ".count"}, 32'(bus.count), 32'(c));
    endtask
    initial begin
`ifdef UD_SWEEP_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01};
`else
        exp_g = '{2'b01, 2'b01, 2'b01};
`endif
        {bus.req0, bus.req1, bus.dir0, bus.dir1} = 4'b0;
        {bus.start0, bus.start1, bus.stop0, bus.stop1} = 16'h0;
        #12;
        outs("reset", 2'b00, 0, 0, 0, 4'd0);
        reset = 1'b0;
        // reset mid-RUN: req0 up 2->9, reset at count 5
        bus.req0 = 1; bus.dir0 = 1; bus.start0 = 4'd2; bus.stop0 = 4'd9;
        tick();
        outs("rst_grant", 2'b01, 1, 0, 1, 4'd2);
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk("rst_run.count", 32'(bus.count), 32'(i));
        end
        reset = 1'b1;
        #1;
        outs("rst_async", 2'b00, 0, 0, 0, 4'd0);
        reset = 1'b0;
        tick();
        outs("rst_regrant", 2'b01, 1, 0, 1, 4'd2);
        bus.req0 = 0;
        tick();
        outs("rst_abort", 2'b00, 0, 0, 1, 4'd2);
        // req0 up 3->7; fields altered after grant must be ignored
        bus.req0 = 1; bus.dir0 = 1; bus.start0 = 4'd3; bus.stop0 = 4'd7;
        tick();
        outs("up_grant", 2'b01, 1, 0, 1, 4'd3);
        bus.dir0 = 0; bus.start0 = 4'd12; bus.stop0 = 4'd0;
        for (int i = 4; i <= 6; i++) begin
            tick();
            outs("up_run", 2'b01, 1, 0, 1, 4'(i));
        end
        tick();
        outs("up_done", 2'b01, 1, 1, 1, 4'd7);
        bus.req0 = 0;
        tick();
        outs("up_idle", 2'b00, 0, 0, 1, 4'd7);
        // zero-length sweep
        bus.req0 = 1; bus.start0 = 4'd5; bus.stop0 = 4'd5; bus.dir0 = 1;
        tick();
        outs("zero_done", 2'b01, 1, 1, 1, 4'd5);
        bus.req0 = 0;
        tick();
        outs("zero_idle", 2'b00, 0, 0, 1, 4'd5);
        // req1 down 1->14 through the wrap
        bus.req1 = 1; bus.dir1 = 0; bus.start1 = 4'd1; bus.stop1 = 4'd14;
        tick();
        outs("dn_grant", 2'b10, 1, 0, 0, 4'd1);
        tick();
        outs("dn_0", 2'b10, 1, 0, 0, 4'd0);
        tick();
        outs("dn_15", 2'b10, 1, 0, 0, 4'd15);
        tick();
        outs("dn_done", 2'b10, 1, 1, 0, 4'd14);
        bus.req1 = 0;
        tick();
        outs("dn_idle", 2'b00, 0, 0, 0, 4'd14);
        // both requesting continuously, 0->2 up each
        bus.req0 = 1; bus.dir0 = 1; bus.start0 = 4'd0; bus.stop0 = 4'd2;
        bus.req1 = 1; bus.dir1 = 1; bus.start1 = 4'd0; bus.stop1 = 4'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            outs("arb_grant", exp_g[k], 1, 0, 1, 4'd0);
            tick();
            chk("arb_run.count", 32'(bus.count), 32'd1);
            tick();
            outs("arb_done", exp_g[k], 1, 1, 1, 4'd2);
            tick();
            outs("arb_idle", 2'b00, 0, 0, 1, 4'd2);
        end
        bus.req0 = 0; bus.req1 = 0;
        tick();
        outs("arb_quiet", 2'b00, 0, 0, 1, 4'd2);
        // abort req0 at count 4 with req1 pending
        bus.req0 = 1; bus.dir0 = 1; bus.start0 = 4'd0; bus.stop0 = 4'd10;
        tick();
        outs("ab_grant", 2'b01, 1, 0, 1, 4'd0);
        bus.req1 = 1; bus.dir1 = 0; bus.start1 = 4'd8; bus.stop1 = 4'd6;
        for (int i = 1; i <= 4; i++) begin
            tick();
            outs("ab_run", 2'b01, 1, 0, 1, 4'(i));
        end
        bus.req0 = 0;
        tick();
        outs("ab_idle", 2'b00, 0, 0, 1, 4'd4);
        tick();
        outs("ab_req1", 2'b10, 1, 0, 0, 4'd8);
        bus.req1 = 0;
        tick();
        outs("ab_req1_abort", 2'b00, 0, 0, 0, 4'd8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ud_sweep_ctrl.md
# ud_sweep_ctrl

Controller that shares one WIDTH-bit up/down counter datapath between two requesters. Each requester asks for a "sweep" from a start value to a stop value in a chosen direction. The block arbitrates, loads the counter, steps it once per clock with modular wrap-around, and signals completion. It sits above the up/down counter in the counter/timer subsystem and owns its load, step and direction controls.

## Interface
- WIDTH, default 4: counter width in bits.

- clk  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- req0, req1  input  1  sweep request; held high until `done` is seen, or dropped to abort
- dir0, dir1  input  1  requested direction; 1 = up, 0 = down
- start0, start1  input  WIDTH  sweep start value
- stop0, stop1  input  WIDTH  sweep stop value
- gnt  output  2  one-hot grant; bit i = requester i owns the counter
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse (DONE state)
- m  output  1  latched direction of the current sweep (1 = up)
- count  output  WIDTH  counter value

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- Request fields (dir, start, stop) are sampled only on the grant edge. Changes after that edge are ignored.
- IDLE:
  - If any req is high, select a winner.
  - On the same edge: gnt = winner, m = dir, count = start, stop latched.
  - Next state is DONE if start == stop, else RUN.
  - If no req is high, all outputs hold.
- RUN, each edge:
  - count steps by ±1 mod 2^WIDTH.
  - Up: all-ones wraps to 0. Down: 0 wraps to all-ones.
  - If the stepped value equals the latched stop, next state is DONE.
  - Abort: if the granted req is low at the edge, go to IDLE with gnt = 0. count holds its last value and no done is issued. The abort check takes precedence over stepping.
- DONE:
  - done = 1, count = stop, gnt held.
  - Next edge: go to IDLE, gnt = 0, done = 0. count holds stop.
  - A req still high in IDLE is treated as a new request.
- Arbitration applies only in IDLE; see Configuration. A losing request stays pending with no timeout.
- A non-granted req toggling during RUN or DONE has no effect.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, gnt = 2'b00, busy = 0, done = 0, m = 0, count = 0.
  - Round-robin pointer favours requester 0.
- Let E0 be the edge at which IDLE samples a request, and d the modular distance from start to stop in direction m:
  - After E0: gnt and busy high, count = start.
  - After E0+d: state DONE, count = stop, done = 1.
  - After E0+d+1: IDLE, gnt = 0, busy = 0, done = 0.
  - With d = 0, DONE is entered at E0.
- Minimum gap between consecutive grants is one IDLE cycle. The earliest next grant is at edge E0+d+2.
- A full-circle sweep is impossible: start == stop means zero steps. The maximum is d = 2^WIDTH − 1.
- Reset asserted mid-sweep aborts immediately with no done. After reset release, the first rising edge is handled as IDLE.

## Configuration
- UD_SWEEP_RR_EN defined: round-robin arbitration.
  - When both req are high in IDLE, the requester not granted most recently wins.
  - The pointer updates on every grant, including grants that are later aborted.
- UD_SWEEP_RR_EN undefined: fixed priority, req0 always wins. There is no pointer register.
- In both modes, a single active request is granted immediately.

## Test plan
- Reset mid-RUN (req0, up, 2→9, reset pulsed at count = 5) -> all outputs return to reset values immediately; no done; a new req0 is granted normally after release.
- req0, dir0 = 1, start0 = 3, stop0 = 7 -> gnt = 01, count 3,4,5,6,7; done high exactly one cycle with count = 7; gnt = 00 the next cycle.
- req1, dir1 = 0, start1 = 1, stop1 = 14 (WIDTH = 4) -> count 1,0,15,14; done at 14; m = 0 throughout.
- req0 with start0 = stop0 = 5 -> done one cycle after the grant edge; count = 5; no RUN cycle.
- req0 and req1 both held high continuously, each with 0→2 sweeps:
  - With UD_SWEEP_RR_EN: grants alternate 01,10,01.
  - Without: 01 every time; req1 is never granted.
- req0, up, 0→10; req0 dropped when count = 4 -> next edge IDLE, gnt = 00, count holds 4, no done; a pending req1 is granted one edge later.
